ycr_clk_ctrl_mc: RTL



---
 rtl/ycr_clk_ctrl_mc.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/ycr_clk_ctrl_mc.sv
// rtl/ycr_clk_ctrl_mc.sv - multi-channel clock controller with per-channel sleep/wake handshake FSM
// Optional idle auto-sleep feature: define YCR_CLKCTRL_IDLE_EN.

module ycr_cg (
  input  logic clk,
  input  logic en,
  input  logic te,
  output logic clk_o
);
  logic en_q;

  // Enable captured while clk is low, so the AND below can never chop a high phase.
  always_ff @(negedge clk) en_q <= en | te;

  assign clk_o = clk & en_q;
endmodule

module ycr_clk_ctrl_mc #(
  parameter int NUM_CH    = 3,
  parameter int CNT_W     = 4,
  parameter int DRAIN_CYC = 2,
  parameter int WAKE_CYC  = 3,
  parameter int IDLE_W    = 8,
  parameter int IDLE_CYC  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              test_mode,
  input  logic              test_rst,
  input  logic [NUM_CH-1:0] sleep_req_i,
  input  logic [NUM_CH-1:0] wake_req_i,
  input  logic [NUM_CH-1:0] busy_i,
  output logic              clk_alw_on_o,
  output logic              clk_dbgc_o,
  output logic [NUM_CH-1:0] clk_o,
  output logic [NUM_CH-1:0] clk_en_o,
  output logic [NUM_CH-1:0] sleep_ack_o,
  output logic [NUM_CH-1:0] rdy_o
);
  typedef enum logic [1:0] {ST_RUN = 2'd0, ST_DRAIN = 2'd1, ST_GATED = 2'd2, ST_WAKE = 2'd3} state_t;

  localparam logic [CNT_W-1:0] DRAIN_LD = CNT_W'((DRAIN_CYC == 0) ? 0 : DRAIN_CYC - 1);
  localparam logic [CNT_W-1:0] WAKE_LD  = CNT_W'((WAKE_CYC == 0) ? 0 : WAKE_CYC - 1);

  logic             ctrl_rst;
  state_t           state_q [NUM_CH];
  state_t           state_d [NUM_CH];
  logic [CNT_W-1:0] cnt_q   [NUM_CH];
  logic [CNT_W-1:0] cnt_d   [NUM_CH];
  logic [NUM_CH-1:0] en_d, ack_d, rdy_d, go_sleep, abort;

  assign ctrl_rst     = test_mode ? test_rst : rst;
  assign clk_alw_on_o = clk;
  assign clk_dbgc_o   = clk;

`ifdef YCR_CLKCTRL_IDLE_EN
  logic [IDLE_W-1:0] idle_q [NUM_CH];
  logic [IDLE_W-1:0] idle_d [NUM_CH];

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      go_sleep[i] = sleep_req_i[i] | (idle_q[i] == IDLE_W'(IDLE_CYC));
      abort[i]    = wake_req_i[i] | busy_i[i];
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      idle_d[i] = '0;
      if (state_q[i] == ST_RUN && state_d[i] == ST_RUN &&
          !busy_i[i] && !wake_req_i[i] && !sleep_req_i[i])
        idle_d[i] = (idle_q[i] < IDLE_W'(IDLE_CYC)) ? idle_q[i] + IDLE_W'(1) : idle_q[i];
    end
  end

  always_ff @(posedge clk or posedge ctrl_rst) begin
    if (ctrl_rst) begin
      for (int i = 0; i < NUM_CH; i++) idle_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) idle_q[i] <= idle_d[i];
    end
  end
`else
  logic unused_busy;
  assign unused_busy = ^busy_i;
  assign go_sleep    = sleep_req_i;
  assign abort       = wake_req_i;
`endif

  always_ff @(posedge clk or posedge ctrl_rst) begin
    if (ctrl_rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= ST_RUN;
        cnt_q[i]   <= '0;
      end
      clk_en_o    <= '1;
      rdy_o       <= '1;
      sleep_ack_o <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      clk_en_o    <= en_d;
      rdy_o       <= rdy_d;
      sleep_ack_o <= ack_d;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        ST_RUN: begin
          if (go_sleep[i] && !wake_req_i[i]) begin
            if (DRAIN_CYC == 0) begin
              state_d[i] = ST_GATED;
            end else begin
              state_d[i] = ST_DRAIN;
              cnt_d[i]   = DRAIN_LD;
            end
          end
        end
        ST_DRAIN: begin
          if (abort[i])
            state_d[i] = ST_RUN;
          else if (cnt_q[i] == '0)
            state_d[i] = ST_GATED;
          else
            cnt_d[i] = cnt_q[i] - CNT_W'(1);
        end
        ST_GATED: begin
          if (wake_req_i[i]) begin
            if (WAKE_CYC == 0) begin
              state_d[i] = ST_RUN;
            end else begin
              state_d[i] = ST_WAKE;
              cnt_d[i]   = WAKE_LD;
            end
          end
        end
        ST_WAKE: begin
          if (cnt_q[i] == '0)
            state_d[i] = ST_RUN;
          else
            cnt_d[i] = cnt_q[i] - CNT_W'(1);
        end
        default: begin
          state_d[i] = ST_RUN;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so the registered flags line up with the state register.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      en_d[i]  = (state_d[i] != ST_GATED);
      ack_d[i] = (state_d[i] == ST_GATED);
      rdy_d[i] = (state_d[i] == ST_RUN);
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_cg
    ycr_cg u_cg (
      .clk   (clk),
      .en    (clk_en_o[g]),
      .te    (test_mode),
      .clk_o (clk_o[g])
    );
  end
endmodule
